key_debounce_multi: RTL and testbench



---
 rtl/key_debounce_multi.sv | 179 +++++++++++++++++
 tb/tb_key_debounce_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_multi
// Description : N independent active-low key debouncers on the tick clock.
//               Each channel has a 2-flop synchroniser and a four-state
//               IDLE/FALL/HOLD/RISE debounce FSM. It produces a debounced
//               level, a one-cycle press pulse and a one-cycle release pulse.
//               Optional auto-repeat of key_press while a key is held is
//               enabled by defining the macro KEY_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
   parameter int N_KEYS         = 4,
   parameter int CNT_W          = 8,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int REPEAT_DELAY   = 200,
   parameter int REPEAT_PERIOD  = 50
) (
   input  logic              clk_out,
   input  logic              timer_rst,
   input  logic [N_KEYS-1:0] tap,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FALL = 2'd1,
      HOLD = 2'd2,
      RISE = 2'd3
   } state_t;

   // Last count value of a debounce window; the compare happens before the
   // counter could ever overflow.
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

`ifdef KEY_REPEAT_EN
   // One extra bit so that REPEAT_DELAY == 2^CNT_W is still representable.
   localparam int               RCW        = CNT_W + 1;
   localparam logic [RCW-1:0]   REP_DELAY  = RCW'(REPEAT_DELAY);
   // Reloading to DELAY-PERIOD makes every later pulse land PERIOD cycles on.
   localparam logic [RCW-1:0]   REP_RELOAD = RCW'(REPEAT_DELAY - REPEAT_PERIOD);
`else
   // Repeat timing is irrelevant without auto-repeat; keep the parameters
   // referenced so they do not show up as dangling.
   logic [1:0] unused_repeat_params;
   assign unused_repeat_params = {REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

   // Next-cycle "in FALL or RISE" per channel, registered into busy below.
   logic [N_KEYS-1:0] busy_nx;

   genvar i;
   generate
      for (i = 0; i < N_KEYS; i++) begin : g_ch
         logic             sync1;
         logic             s;
         state_t           state;
         logic [CNT_W-1:0] cnt;
         logic             level_q;
         logic             press_q;
         logic             release_q;
`ifdef KEY_REPEAT_EN
         logic [RCW-1:0]   rcnt;
         logic [RCW-1:0]   rcnt_inc;
         assign rcnt_inc = rcnt + RCW'(1);
`endif

         // Two-flop synchroniser; resets to the released level.
         always_ff @(posedge clk_out or posedge timer_rst) begin
            if (timer_rst) begin
               sync1 <= 1'b1;
               s     <= 1'b1;
            end else begin
               sync1 <= tap[i];
               s     <= sync1;
            end
         end

         // Busy flag for the state this channel will be in after the edge.
         assign busy_nx[i] = ((state == IDLE) && !s)
                          || ((state == FALL) && !s && (cnt != DB_LAST))
                          || ((state == HOLD) &&  s)
                          || ((state == RISE) &&  s && (cnt != DB_LAST));

         // Debounce FSM with registered level/press/release outputs.
         always_ff @(posedge clk_out or posedge timer_rst) begin
            if (timer_rst) begin
               state     <= IDLE;
               cnt       <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
               rcnt      <= '0;
`endif
            end else begin
               press_q   <= 1'b0;
               release_q <= 1'b0;
               case (state)
                  IDLE: begin
                     if (!s) begin
                        state <= FALL;
                        cnt   <= '0;
                     end
                  end
                  FALL: begin
                     if (s) begin
                        // Press bounce: back to idle silently.
                        state <= IDLE;
                        cnt   <= '0;
                     end else if (cnt == DB_LAST) begin
                        state   <= HOLD;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                        rcnt    <= '0;
`endif
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  HOLD: begin
                     if (s) begin
                        state <= RISE;
                        cnt   <= '0;
                     end else begin
`ifdef KEY_REPEAT_EN
                        if (rcnt_inc == REP_DELAY) begin
                           press_q <= 1'b1;
                           rcnt    <= REP_RELOAD;
                        end else begin
                           rcnt <= rcnt_inc;
                        end
`endif
                     end
                  end
                  RISE: begin
                     if (!s) begin
                        // Release bounce: key still held, repeat count kept.
                        state <= HOLD;
                        cnt   <= '0;
                     end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  default: begin
                     state <= IDLE;
                     cnt   <= '0;
                  end
               endcase
            end
         end

         assign key_level[i]   = level_q;
         assign key_press[i]   = press_q;
         assign key_release[i] = release_q;
      end
   endgenerate

   // Registered OR of all channels that are mid-debounce.
   always_ff @(posedge clk_out or posedge timer_rst) begin
      if (timer_rst) begin
         busy <= 1'b0;
      end else begin
         busy <= |busy_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_multi
// Description : Directed self-checking bench for key_debounce_multi with
//               N_KEYS=4, DEBOUNCE_TICKS=4 (press/release latency 7 cycles).
//               Repeat section active only when KEY_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

   logic       clk_out;
   logic       timer_rst;
   logic [3:0] tap;
   logic [3:0] key_level;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic       busy;

   int checks = 0;
   int errors = 0;

   key_debounce_multi #(
      .N_KEYS         (4),
      .CNT_W          (8),
      .DEBOUNCE_TICKS (4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (5)
   ) dut (
      .clk_out     (clk_out),
      .timer_rst   (timer_rst),
      .tap         (tap),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .busy        (busy)
   );

   initial clk_out = 1'b0;
   always #5 clk_out = ~clk_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge (inputs driven and outputs sampled here).
   task automatic step(input int n);
      repeat (n) @(negedge clk_out);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_level"},   {28'd0, key_level},   32'h0);
      chk({tag, "_press"},   {28'd0, key_press},   32'h0);
      chk({tag, "_release"}, {28'd0, key_release}, 32'h0);
      chk({tag, "_busy"},    {31'd0, busy},        32'h0);
   endtask

   initial begin
      logic saw_busy;
      int   exp_p;

      // ---------------- reset / idle ----------------
      timer_rst = 1'b1;
      tap       = 4'hF;
      step(3);
      chk_quiet("reset");
      timer_rst = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step(1);
         chk("idle_busy",  {31'd0, busy},      32'h0);
         chk("idle_level", {28'd0, key_level}, 32'h0);
      end

      // ---------------- clean press on ch0 ----------------
      tap = 4'b1110;
      step(3);
      chk("press0_busy", {31'd0, busy}, 32'h1);
      step(3);
      chk("press0_early", {28'd0, key_press}, 32'h0);
      step(1);
      chk("press0_pulse", {28'd0, key_press}, 32'h1);
      chk("press0_level", {28'd0, key_level}, 32'h1);
      chk("press0_nobusy", {31'd0, busy}, 32'h0);
      step(1);
      chk("press0_once", {28'd0, key_press}, 32'h0);
      chk("press0_hold", {28'd0, key_level}, 32'h1);
      step(12);
      // clean release of ch0
      tap = 4'hF;
      step(6);
      chk("rel0_early_lvl", {28'd0, key_level},   32'h1);
      chk("rel0_early_rel", {28'd0, key_release}, 32'h0);
      step(1);
      chk("rel0_pulse", {28'd0, key_release}, 32'h1);
      chk("rel0_level", {28'd0, key_level},   32'h0);
      step(1);
      chk("rel0_once", {28'd0, key_release}, 32'h0);
      step(5);

      // ---------------- press bounce on ch1 ----------------
      saw_busy = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k < 3 || (k >= 5 && k < 8)) tap = 4'b1101;
         else                            tap = 4'hF;
         step(1);
         if (busy) saw_busy = 1'b1;
         chk("bounce1_press", {28'd0, key_press}, 32'h0);
         chk("bounce1_level", {28'd0, key_level}, 32'h0);
      end
      chk("bounce1_sawbusy", {31'd0, saw_busy}, 32'h1);
      chk("bounce1_busy_end", {31'd0, busy}, 32'h0);

      // ---------------- release bounce + clean release on ch2 ----------------
      tap = 4'b1011;
      step(10);
      chk("hold2_level", {28'd0, key_level}, 32'h4);
      tap = 4'hF;
      step(1);
      chk("rb2_lvl_a", {28'd0, key_level}, 32'h4);
      step(1);
      tap = 4'b1011;
      step(1);
      tap = 4'hF;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk("rb2_level", {28'd0, key_level},   32'h4);
         chk("rb2_norel", {28'd0, key_release}, 32'h0);
      end
      step(1);
      chk("rb2_release", {28'd0, key_release}, 32'h4);
      chk("rb2_dropped", {28'd0, key_level},   32'h0);
      step(1);
      chk("rb2_once", {28'd0, key_release}, 32'h0);
      step(5);

      // ---------------- all channels together, then reset mid-RISE ----------------
      tap = 4'b0000;
      step(6);
      chk("all_early", {28'd0, key_press}, 32'h0);
      step(1);
      chk("all_press", {28'd0, key_press}, 32'hF);
      chk("all_level", {28'd0, key_level}, 32'hF);
      step(5);
      tap = 4'hF;
      step(4);
      chk("all_rise_busy",  {31'd0, busy},      32'h1);
      chk("all_rise_level", {28'd0, key_level}, 32'hF);
      #1;
      timer_rst = 1'b1;
      #1;
      chk_quiet("async_rst");
      step(3);
      chk_quiet("in_rst");
      timer_rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("post_rst_rel",   {28'd0, key_release}, 32'h0);
         chk("post_rst_press", {28'd0, key_press},   32'h0);
         chk("post_rst_level", {28'd0, key_level},   32'h0);
      end

`ifdef KEY_REPEAT_EN
      // ---------------- auto-repeat on ch0 ----------------
      tap = 4'b1110;
      for (int k = 1; k <= 45; k++) begin
         if (k == 41) tap = 4'hF;
         step(1);
         exp_p = (k == 7 || (k >= 17 && k <= 42 && ((k - 17) % 5) == 0)) ? 1 : 0;
         chk("repeat_press", {28'd0, key_press}, exp_p);
      end
      tap = 4'hF;
      step(10);
      chk("repeat_released", {28'd0, key_level}, 32'h0);
`else
      exp_p = 0;
      tap = 4'b1110;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         exp_p = (k == 7) ? 1 : 0;
         chk("norepeat_press", {28'd0, key_press}, exp_p);
      end
      tap = 4'hF;
      step(10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
